// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One bit is moved per clock: the {bcd, bin} pair is shifted right by one,
// then every BCD nibble that reads >= 8 is reduced by 3. After 4*DIGITS
// iterations the binary register holds the value of the operand.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, sampled only while idle
//   num_BCD  in   packed BCD operand, digit 0 in [3:0]
//   busy     out  high while a conversion is running
//   done     out  one-cycle pulse when num_bin/err are updated
//   num_bin  out  binary result (0 for an invalid operand), held until next done
//   err      out  last accepted operand contained a nibble > 9
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   num_BCD,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      num_bin,
  output logic                  err
);

  localparam int N     = 4 * DIGITS;
  localparam int CNT_W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       bcd_q, bcd_d;
  logic [N-1:0]       bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inv_q, inv_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   num_bin_q, num_bin_d;
  logic               err_q, err_d;

  // Per-digit helpers
  logic [DIGITS-1:0]  nib_bad;   // operand nibble > 9
  logic [2*N-1:0]     shifted;   // {bcd, bin} after the right shift
  logic [N-1:0]       bcd_sh;
  logic [N-1:0]       bin_sh;
  logic [N-1:0]       bcd_fix;   // shifted BCD after the -3 correction

  assign shifted = {bcd_q, bin_q} >> 1;
  assign bcd_sh  = shifted[2*N-1:N];
  assign bin_sh  = shifted[N-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib_bad[gi] = (num_BCD[4*gi +: 4] > 4'd9);
      // A nibble >= 8 after the shift came from a decimal "ten" that was
      // halved as binary (16/2 = 8); subtracting 3 restores the 10/2 = 5 weight.
      assign bcd_fix[4*gi +: 4] = (bcd_sh[4*gi +: 4] >= 4'd8)
                                  ? (bcd_sh[4*gi +: 4] - 4'd3)
                                  : bcd_sh[4*gi +: 4];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      done_q    <= 1'b0;
      num_bin_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      done_q    <= done_d;
      num_bin_q <= num_bin_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    done_d    = 1'b0;
    num_bin_d = num_bin_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = num_BCD;
          bin_d   = '0;
          inv_d   = |nib_bad;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          // Invalid operands run the full count so latency stays constant;
          // their result is forced to zero.
          num_bin_d = inv_q ? '0 : BIN_W'(bin_sh);
          err_d     = inv_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign num_bin = num_bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_BCD = 16'h0;
  logic        busy;
  logic        done;
  logic [15:0] num_bin;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num_BCD (num_BCD),
    .busy    (busy),
    .done    (done),
    .num_bin (num_bin),
    .err     (err)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of a packed BCD word; bit 16 flags an invalid nibble.
  function automatic logic [16:0] model(input logic [15:0] bcd);
    int v = 0;
    bit inv = 0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'((bcd >> (4 * i)) & 16'h000F);
      if (d > 9) inv = 1;
      v = v * 10 + d;
    end
    return inv ? {1'b1, 16'h0000} : {1'b0, 16'(v)};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = 16'h0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      r = r | 16'(((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle or in its done cycle. Returns at
  // the negedge where done is seen (or after the cycle budget runs out).
  task automatic conv(input logic [15:0] bcd, input logic [15:0] exp_bin,
                      input logic exp_err, input bit noisy, input int pulse_at,
                      input string tag);
    int n = 0;
    int busy_n = 0;
    start   = 1'b1;
    num_BCD = bcd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (n == pulse_at) begin
        start   = 1'b1;
        num_BCD = 16'h0001;
      end else if (noisy) begin
        start   = 1'($urandom_range(0, 1));
        num_BCD = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, 16);
    check({tag, "_busy_cycles"}, busy_n, 16);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_num_bin"}, num_bin, exp_bin);
    check({tag, "_err"}, err, exp_err);
    $display("conv %s: bcd=%h num_bin=%0d err=%0b exp=%0d/%0b lat=%0d",
             tag, bcd, num_bin, err, exp_bin, exp_err, n);
  endtask

  // Idle window: no done pulse and no busy expected.
  task automatic idle(input int cyc, input string tag);
    int dn = 0;
    int bn = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bn++;
    end
    check({tag, "_done_pulses"}, dn, 0);
    check({tag, "_busy_cycles"}, bn, 0);
  endtask

  logic [15:0] seq_bcd [8] = '{16'h0005, 16'h0009, 16'h0010, 16'h0123,
                               16'h0255, 16'h0999, 16'h1234, 16'h9999};
  logic [15:0] seq_exp [8] = '{16'd5, 16'd9, 16'd10, 16'd123,
                               16'd255, 16'd999, 16'd1234, 16'd9999};

  initial begin
    logic [16:0] m;
    logic [15:0] r;
    int v;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_num_bin", num_bin, 0);
    check("rst_err", err, 0);

    // Release with start already pending: first edge after release accepts.
    rst_n = 1'b1;
    conv(16'h0000, 16'd0, 1'b0, 1'b0, -1, "zero");
    idle(3, "after_zero");

    for (int i = 0; i < 8; i++) begin
      conv(seq_bcd[i], seq_exp[i], 1'b0, 1'b0, -1, $sformatf("seq%0d", i));
      idle(2, $sformatf("seq%0d_gap", i));
    end

    // Invalid operand, then a valid one back-to-back
    conv(16'h12A4, 16'd0, 1'b1, 1'b0, -1, "invalid");
    conv(16'h0042, 16'd42, 1'b0, 1'b0, -1, "after_invalid");
    idle(2, "after_invalid_gap");

    // start pulse during CONV is ignored
    conv(16'h0777, 16'd777, 1'b0, 1'b0, 5, "ignore_start");
    idle(20, "ignore_start_gap");

    // Reset mid-conversion
    start   = 1'b1;
    num_BCD = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_num_bin", num_bin, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20, "midrst_gap");
    check("midrst_num_bin_held", num_bin, 0);
    $display("midrst: busy=%0b done=%0b num_bin=%0d", busy, done, num_bin);
    conv(16'h0321, 16'd321, 1'b0, 1'b0, -1, "after_midrst");

    // Random 16-bit operands (valid and invalid), back-to-back, noisy inputs
    for (int i = 0; i < 200; i++) begin
      r = 16'($urandom);
      if (i % 2 == 0) r = to_bcd(int'($urandom_range(0, 9999)));
      m = model(r);
      conv(r, m[15:0], m[16], 1'b1, -1, $sformatf("rnd%0d", i));
    end
    idle(2, "after_rnd");

    // Round trip: decimal -> BCD -> this block, back-to-back
    for (int i = 0; i < 900; i++) begin
      if (i < 150)      v = i;
      else if (i < 300) v = 9850 + (i - 150);
      else              v = int'($urandom_range(0, 9999));
      conv(to_bcd(v), 16'(v), 1'b0, 1'b0, -1, $sformatf("rt%0d", v));
    end
    idle(3, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter for the calculator datapath. It is the inverse of the combinational binary-to-BCD stage: it takes the packed 4-digit BCD operand assembled from keypad entry and returns its 16-bit binary value for the ALU. Conversion uses the reverse double-dabble algorithm (shift right, then subtract 3), one bit per clock, controlled by a start/busy/done handshake.

## Interface
- DIGITS, 4: number of packed BCD digits. The input is 4*DIGITS bits wide and the conversion takes 4*DIGITS iterations.
- BIN_W, 16: binary result width. Must be at least 4*DIGITS.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- start  input  1  conversion request; sampled only in IDLE.
- num_BCD  input  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]; sampled only on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when num_bin and err are updated.
- num_bin  output  BIN_W  binary result; held until the next done.
- err  output  1  the last accepted operand had a nibble > 9; held until the next done.

## Operation
- Reset values: state IDLE, busy 0, done 0, num_bin 0, err 0, iteration counter 0, shift registers 0.
- States: IDLE, CONV.
- IDLE, start=1:
  - load bcd_reg <= num_BCD and bin_reg <= 0;
  - latch inv = (any nibble of num_BCD > 9);
  - set cnt <= 0 and go to CONV.
- IDLE, start=0: hold.
- CONV, one iteration per cycle:
  - shift the concatenation {bcd_reg, bin_reg} right by 1; the bcd_reg LSB enters the bin_reg MSB;
  - then, in the same cycle and combinationally on the shifted value, subtract 3 from every bcd_reg nibble that is >= 8;
  - cnt increments each iteration.
- Completion: on the iteration with cnt == 4*DIGITS-1, in the same edge:
  - num_bin <= final bin_reg, or 0 if inv;
  - err <= inv;
  - done <= 1;
  - state <= IDLE.
- done is cleared on the next edge unless another conversion completes.
- An invalid operand still runs the full iteration count, so latency is constant.
- start while in CONV is ignored: no queuing and no restart. num_BCD changes during CONV are ignored.
- Width rules:
  - no arithmetic overflow is possible, since the maximum value 10^DIGITS-1 fits in 4*DIGITS bits;
  - bits of num_bin above 4*DIGITS are 0;
  - after the final iteration bcd_reg is all zero for valid input. This is checkable in simulation only and has no port.

## Timing
- Start accepted at edge k, so busy=1 from edge k through edge k+4*DIGITS.
- Iterations run on edges k+1 through k+4*DIGITS. Default: 16 iterations.
- num_bin, err and done update at edge k+4*DIGITS (edge k+16 by default). done is high for exactly the one cycle after that edge.
- busy falls on the same edge where done rises; busy and done are never high together.
- Back-to-back: start high during the done cycle is accepted at the next edge. The sustained rate is one result per 4*DIGITS+1 cycles.
- Reset asserted mid-conversion:
  - immediate return to IDLE with all outputs 0;
  - no done pulse;
  - the operand is discarded.
- Reset deasserted with start=1: start is sampled at the first rising edge after release.

## Test plan
- Reset, then start with num_BCD=16'h0000 -> done exactly 16 cycles after the accepting edge; num_bin=0, err=0; busy high for 16 cycles.
- Sequence 16'h0005, 16'h0009, 16'h0010, 16'h0123, 16'h0255, 16'h0999, 16'h1234, 16'h9999 -> num_bin = 5, 9, 10, 123, 255, 999, 1234, 9999; err=0 each time.
- num_BCD=16'h12A4 -> done after 16 cycles, num_bin=0, err=1. A following 16'h0042 -> num_bin=42, err=0.
- Start 16'h0777, then pulse start with num_BCD=16'h0001 at cycle 5 of the conversion -> single done, num_bin=777, and no second conversion.
- Start 16'h9999, assert rst_n=0 at iteration 8 and release -> busy=0, done never pulses, num_bin=0. A new start with 16'h0321 -> num_bin=321.
- Round trip: drive bin_to_bcd_double_dabble with 0..9999 and feed its num_BCD into this block back-to-back (start during each done cycle) -> num_bin equals the original value for every input, with no lost or duplicated done pulses.
